// File: rtl/vehicle_sensor_conditioner.sv
// Conditions a bouncy loop-detector input into a vehicle-present request,
// with arrival pulse/count, hold-over after departure and stuck-high detection.
module vehicle_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned HOLD_CYCLES     = 100_000_000,
    parameter int unsigned STUCK_CYCLES    = 1_500_000_000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_raw,
    input  logic             count_clear,
    output logic             sensor,
    output logic             vehicle_pulse,
    output logic [CNT_W-1:0] vehicle_count,
    output logic             fault
);

    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int unsigned STUCK_W = (STUCK_CYCLES > 1)    ? $clog2(STUCK_CYCLES)    : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    logic               sync_q;
    logic               raw_s;
    logic               db;
    logic [DB_W-1:0]    db_cnt;
    state_t             state;
    state_t             state_nxt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic [STUCK_W-1:0] stuck_cnt;
    logic [STUCK_W-1:0] stuck_nxt;
    logic               arrive_c;

    // Two-flop synchronizer for the asynchronous detector input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
            raw_s  <= 1'b0;
        end else begin
            sync_q <= sensor_raw;
            raw_s  <= sync_q;
        end
    end

    // Debounce: accept a new level only after it has been stable long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            db     <= 1'b0;
            db_cnt <= '0;
        end else if (raw_s == db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db     <= ~db;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Presence FSM state and timers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            stuck_cnt <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            stuck_cnt <= stuck_nxt;
        end
    end

    // Timers default to zero so each is cleared whenever its state is entered
    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        stuck_nxt = '0;
        arrive_c  = 1'b0;
        case (state)
            IDLE: begin
                if (db) begin
                    state_nxt = PRESENT;
                    arrive_c  = 1'b1;
                end
            end
            PRESENT: begin
                if (!db) begin
                    state_nxt = HOLD;
                end else if (stuck_cnt == STUCK_LAST) begin
                    state_nxt = FAULT;
                end else begin
                    stuck_nxt = stuck_cnt + STUCK_W'(1);
                end
            end
            HOLD: begin
                if (db) begin
                    state_nxt = PRESENT;
                    arrive_c  = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            FAULT: begin
                if (!db) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs registered from the next state so they align with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            sensor        <= 1'b0;
            fault         <= 1'b0;
            vehicle_pulse <= 1'b0;
        end else begin
            sensor        <= (state_nxt == PRESENT) || (state_nxt == HOLD);
            fault         <= (state_nxt == FAULT);
            vehicle_pulse <= arrive_c;
        end
    end

    // Saturating arrival counter; clear has priority over a coincident pulse
    always_ff @(posedge clk) begin
        if (rst || count_clear) begin
            vehicle_count <= '0;
        end else if (vehicle_pulse && (vehicle_count != '1)) begin
            vehicle_count <= vehicle_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed bench for vehicle_sensor_conditioner with small timing parameters.
module tb_vehicle_sensor_conditioner;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             sensor_raw;
    logic             count_clear;
    logic             sensor;
    logic             vehicle_pulse;
    logic [CNT_W-1:0] vehicle_count;
    logic             fault;

    int checks;
    int errors;

    vehicle_sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .STUCK_CYCLES   (50),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_raw   (sensor_raw),
        .count_clear  (count_clear),
        .sensor       (sensor),
        .vehicle_pulse(vehicle_pulse),
        .vehicle_count(vehicle_count),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  raw;
        logic  clr;
        logic  rst;
        int    n;
        logic  e_sensor;
        logic  e_pulse;
        logic  e_fault;
        int    e_count;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input int s, input int p, input int f, input int c);
        check({nm, ".sensor"}, int'(sensor), s);
        check({nm, ".pulse"}, int'(vehicle_pulse), p);
        check({nm, ".fault"}, int'(fault), f);
        check({nm, ".count"}, int'(vehicle_count), c);
    endtask

    initial begin
        int exp_count;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        sensor_raw  = 1'b0;
        count_clear = 1'b0;

        // raw, clr, rst, edges, sensor, pulse, fault, count
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 2,  1'b0, 1'b0, 1'b0, 0, "reset"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0, 0, "glitch_hi"});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 0, "glitch_lo"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 6,  1'b0, 1'b0, 1'b0, 0, "arr_pre"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 0, "arr_pulse"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1, "arr_count"});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 7,  1'b1, 1'b0, 1'b0, 1, "dep_hold"});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 9,  1'b1, 1'b0, 1'b0, 1, "dep_hold_last"});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1, "dep_idle"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 7,  1'b1, 1'b1, 1'b0, 1, "arr2_pulse"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 2, "arr2_count"});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 7,  1'b1, 1'b0, 1'b0, 2, "rearr_hold"});
        for (int i = 0; i < 6; i++)
            vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2, "rearr_cont"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 2, "rearr_pulse"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 3, "rearr_count"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 48, 1'b1, 1'b0, 1'b0, 3, "stuck_pre"});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 3, "stuck_fault"});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 6,  1'b0, 1'b0, 1'b1, 3, "fault_hold"});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 3, "fault_clear"});

        foreach (vecs[i]) begin
            sensor_raw  = vecs[i].raw;
            count_clear = vecs[i].clr;
            rst         = vecs[i].rst;
            step(vecs[i].n);
            check_all(vecs[i].name, int'(vecs[i].e_sensor), int'(vecs[i].e_pulse),
                      int'(vecs[i].e_fault), vecs[i].e_count);
        end

        // Saturation: repeated clean arrivals must stop at the maximum count
        exp_count = 3;
        for (int i = 0; i < 13; i++) begin
            sensor_raw = 1'b1;
            step(7);
            check("sat_pulse", int'(vehicle_pulse), 1);
            step(1);
            exp_count = (exp_count < 15) ? exp_count + 1 : 15;
            check("sat_count", int'(vehicle_count), exp_count);
            sensor_raw = 1'b0;
            step(17);
            check("sat_idle", int'(sensor), 0);
        end

        // Clear coincident with an arrival pulse wins
        sensor_raw = 1'b1;
        step(7);
        check("clr_pulse", int'(vehicle_pulse), 1);
        count_clear = 1'b1;
        step(1);
        check("clr_count", int'(vehicle_count), 0);
        count_clear = 1'b0;

        // Build a nonzero count through a HOLD re-arrival, then reset in HOLD
        sensor_raw = 1'b0;
        step(7);
        check("rst_hold1", int'(sensor), 1);
        sensor_raw = 1'b1;
        step(8);
        check("rst_rearr_count", int'(vehicle_count), 1);
        sensor_raw = 1'b0;
        step(7);
        check_all("rst_hold2", 1, 0, 0, 1);
        rst = 1'b1;
        step(1);
        check_all("rst_in_hold", 0, 0, 0, 0);

        // After release a full sync + debounce interval precedes sensor
        rst        = 1'b0;
        sensor_raw = 1'b1;
        step(6);
        check("post_rst_pre", int'(sensor), 0);
        step(1);
        check("post_rst_sensor", int'(sensor), 1);
        check("post_rst_pulse", int'(vehicle_pulse), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
